sorted_coeff_mac: RTL and testbench
===================================

Name: sorted_coeff_mac

Overview:
- Processing element that sits directly downstream of the coefficient sort stage.
- Consumes one pixel window together with the sort stage's outputs: sign-magnitude kernel coefficients in ascending magnitude order, plus their original indices.
- Computes the signed dot product sum_j coef_j*pix_j multiplierlessly with the differential-coefficient method: acc += (mag[r]-mag[r-1]) * S_r, where S_r is the signed sum of pixels whose coefficient rank >= r.
- Iterates one rank per clock, with valid/ready handshakes on both sides.

Parameters:
KERNEL_SIZE, 11, coefficient width: bit [KERNEL_SIZE-1] is the sign (1=negative), lower bits are the magnitude
IMAGE_SIZE, 9, unsigned pixel width
NUM_VALS, 4, coefficients/pixels per window
SEL_W, 2, index width, equal to $clog2(NUM_VALS)
ACC_W, 22, result width, equal to KERNEL_SIZE-1+IMAGE_SIZE+$clog2(NUM_VALS)+1

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  window and coefficients valid
in_ready  out  1  block can accept a window
sort_coef  in  KERNEL_SIZE x NUM_VALS  coefficients, ascending magnitude, index 0 smallest
sel  in  SEL_W x NUM_VALS  original kernel index of sort_coef[r]
pix  in  IMAGE_SIZE x NUM_VALS  unsigned pixels, indexed by original kernel index
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
result  out  ACC_W signed  dot product
sel_err  out  1  sel was not a permutation, qualified by out_valid

Behaviour:
- Reset, asynchronous and active-low: state=IDLE, in_ready=1, out_valid=0, result=0, sel_err=0, acc=0, rank counter=0.
- FSM IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register sort_coef, sel and pix; clear acc; rank=0; go to RUN.
  - Compute sel_err (any duplicate sel value) and register it.
- FSM RUN:
  - in_ready=0.
  - Each cycle: diff = mag[rank] - (rank==0 ? 0 : mag[rank-1]), an unsigned KERNEL_SIZE-1 bit value.
  - S_rank = sum over r>=rank of (sign[r] ? -pix[sel[r]] : +pix[sel[r]]), signed, width IMAGE_SIZE+SEL_W+1.
  - acc += diff*S_rank; rank++.
  - After rank NUM_VALS-1, go to DONE and load result=acc.
- FSM DONE:
  - out_valid=1; result and sel_err held stable.
  - On out_ready, go to IDLE with out_valid=0.
  - in_ready is not reasserted until IDLE (no same-cycle bypass).
- Latency:
  - Handshake at edge E0; acc updates at E1..E4; out_valid high after E4.
  - Throughput is one window per NUM_VALS+2 cycles with out_ready tied high.
- Arithmetic and input rules:
  - Magnitudes must be non-decreasing. If mag[r] < mag[r-1], diff is computed as signed and the result still equals the true dot product; no error flag is raised for this case.
  - Sign with magnitude 0 (-0) is treated as +0.
  - ACC_W covers ±NUM_VALS*(2^(KERNEL_SIZE-1)-1)*(2^IMAGE_SIZE-1) with no overflow or saturation.
- sel non-permutation: the computation proceeds using the sel values as given, and sel_err=1 alongside the result.
- in_valid while busy is ignored; the upstream stage holds its data until in_ready.
- out_ready low in DONE holds result indefinitely.
- rst_n low mid-RUN or mid-DONE aborts the window; outputs return to reset values immediately, and the aborted result is never presented.

Decomposition:
- Package gabor_pe_pkg:
  - Localparams KERNEL_SIZE, IMAGE_SIZE, NUM_VALS, SEL_W, ACC_W.
  - Typedefs coef_t, pix_t, sel_t, acc_t.
  - Enum state_t {IDLE, RUN, DONE}.
- One sub-module, suffix_pix_sum: combinational, NUM_VALS registered pixels/signs/sel plus rank in, signed S_rank out.

Test Plan:
- Window 1:
  - Stimulus: sort_coef={11'b00000000000, 11'b10000000111, 11'b00011101000, 11'b10011111110}, sel={3,1,0,2}, pix={10,20,30,40}.
  - Required: result=-5440 four cycles after accept; sel_err=0.
- Extremes:
  - All four coefficients +1023 with all pix=511 -> result=2091012.
  - All four coefficients -1023 with all pix=511 -> result=-2091012.
- Backpressure:
  - Stimulus: out_ready=0 for 10 cycles after out_valid.
  - Required: result stable, in_ready=0 throughout; after out_ready pulse, in_ready=1 next cycle.
- Invalid sel:
  - Stimulus: sel={1,1,0,2}, coefficients and pixels as window 1.
  - Required: sel_err=1, result = sum computed with the given sel.
- Reset mid-RUN:
  - Stimulus: assert rst_n=0 at E2.
  - Required: out_valid=0, in_ready=1, result=0 immediately; the next window computes correctly.
- Back-to-back:
  - Stimulus: three windows with in_valid held and out_ready=1.
  - Required: accepts every 6 cycles; results match the reference model.

Source files
------------

// File: rtl/sorted_coeff_mac_pkg.sv
// gabor_pe_pkg: widths, types and helpers shared by the sorted-coefficient MAC
package gabor_pe_pkg;
    localparam int KERNEL_SIZE = 11;
    localparam int IMAGE_SIZE  = 9;
    localparam int NUM_VALS    = 4;
    localparam int SEL_W       = $clog2(NUM_VALS);
    localparam int ACC_W       = KERNEL_SIZE - 1 + IMAGE_SIZE + $clog2(NUM_VALS) + 1;

    typedef logic [KERNEL_SIZE-1:0]              coef_t;
    typedef logic [IMAGE_SIZE-1:0]               pix_t;
    typedef logic [SEL_W-1:0]                    sel_t;
    typedef logic signed [ACC_W-1:0]             acc_t;
    typedef logic signed [IMAGE_SIZE+SEL_W:0]    sum_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // True when any two sel entries point at the same kernel position
    function automatic logic has_dup(input sel_t [NUM_VALS-1:0] s);
        has_dup = 1'b0;
        for (int i = 0; i < NUM_VALS; i++)
            for (int j = i + 1; j < NUM_VALS; j++)
                if (s[i] == s[j]) has_dup = 1'b1;
    endfunction
endpackage

// File: rtl/sorted_coeff_mac_if.sv
// sorted_coeff_mac_if: window input and result output handshakes
interface sorted_coeff_mac_if;
    import gabor_pe_pkg::*;
    logic                 in_valid;
    logic                 in_ready;
    coef_t [NUM_VALS-1:0] sort_coef;
    sel_t  [NUM_VALS-1:0] sel;
    pix_t  [NUM_VALS-1:0] pix;
    logic                 out_valid;
    logic                 out_ready;
    acc_t                 result;
    logic                 sel_err;

    modport master (output in_valid, sort_coef, sel, pix, out_ready,
                    input  in_ready, out_valid, result, sel_err);
    modport slave  (input  in_valid, sort_coef, sel, pix, out_ready,
                    output in_ready, out_valid, result, sel_err);
endinterface

// File: rtl/sorted_coeff_mac_suffix_pix_sum.sv
// suffix_pix_sum: signed sum of pixels whose coefficient rank is >= rank
module suffix_pix_sum
    import gabor_pe_pkg::*;
(
    input  coef_t [NUM_VALS-1:0] coef,
    input  sel_t  [NUM_VALS-1:0] sel,
    input  pix_t  [NUM_VALS-1:0] pix,
    input  sel_t                 rank,
    output sum_t                 s_rank
);
    // Accumulate the suffix; a negative zero coefficient counts as positive
    always_comb begin
        s_rank = '0;
        for (int r = 0; r < NUM_VALS; r++) begin
            if (sel_t'(r) >= rank) begin
                s_rank = (coef[r][KERNEL_SIZE-1] && |coef[r][KERNEL_SIZE-2:0])
                       ? s_rank - sum_t'(pix[sel[r]])
                       : s_rank + sum_t'(pix[sel[r]]);
            end
        end
    end
endmodule

// File: rtl/sorted_coeff_mac.sv
// sorted_coeff_mac: differential-coefficient dot product, one rank per clock
module sorted_coeff_mac
    import gabor_pe_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    sorted_coeff_mac_if.slave bus
);
    localparam sel_t LAST = sel_t'(NUM_VALS - 1);

    state_t                state_q, state_d;
    sel_t                  rank_q, rank_d;
    acc_t                  acc_q, acc_d;
    acc_t                  result_q, result_d;
    logic                  sel_err_q, sel_err_d;
    coef_t [NUM_VALS-1:0]  coef_q, coef_d;
    sel_t  [NUM_VALS-1:0]  sel_q, sel_d;
    pix_t  [NUM_VALS-1:0]  pix_q, pix_d;
    sum_t                  s_rank;
    logic [KERNEL_SIZE-2:0] mag_cur, mag_prev;
    logic signed [KERNEL_SIZE-1:0] diff;
    acc_t                  step;

    suffix_pix_sum u_sum (
        .coef   (coef_q),
        .sel    (sel_q),
        .pix    (pix_q),
        .rank   (rank_q),
        .s_rank (s_rank)
    );

    // Signed difference keeps the sum exact even for unsorted magnitudes
    assign mag_cur  = coef_q[rank_q][KERNEL_SIZE-2:0];
    assign mag_prev = (rank_q == '0) ? '0 : coef_q[rank_q - sel_t'(1)][KERNEL_SIZE-2:0];
    assign diff     = $signed({1'b0, mag_cur}) - $signed({1'b0, mag_prev});
    assign step     = acc_t'(diff) * acc_t'(s_rank);

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.sel_err   = sel_err_q;

    // Window capture, rank iteration and result hand-off
    always_comb begin
        state_d   = state_q;
        rank_d    = rank_q;
        acc_d     = acc_q;
        result_d  = result_q;
        sel_err_d = sel_err_q;
        coef_d    = coef_q;
        sel_d     = sel_q;
        pix_d     = pix_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                coef_d    = bus.sort_coef;
                sel_d     = bus.sel;
                pix_d     = bus.pix;
                acc_d     = '0;
                rank_d    = '0;
                sel_err_d = has_dup(bus.sel);
                state_d   = RUN;
            end
            RUN: begin
                acc_d  = acc_q + step;
                rank_d = rank_q + sel_t'(1);
                if (rank_q == LAST) begin
                    result_d = acc_q + step;
                    state_d  = DONE;
                end
            end
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any window in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rank_q    <= '0;
            acc_q     <= '0;
            result_q  <= '0;
            sel_err_q <= 1'b0;
            coef_q    <= '0;
            sel_q     <= '0;
            pix_q     <= '0;
        end else begin
            state_q   <= state_d;
            rank_q    <= rank_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            sel_err_q <= sel_err_d;
            coef_q    <= coef_d;
            sel_q     <= sel_d;
            pix_q     <= pix_d;
        end
    end
endmodule

// File: tb/tb_sorted_coeff_mac.sv
// tb_sorted_coeff_mac: randomized windows checked against a direct dot-product model
module tb_sorted_coeff_mac;
    import gabor_pe_pkg::*;

    typedef coef_t [NUM_VALS-1:0] coef_vec_t;
    typedef sel_t  [NUM_VALS-1:0] sel_vec_t;
    typedef pix_t  [NUM_VALS-1:0] pix_vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    sorted_coeff_mac_if bus();
    sorted_coeff_mac dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint ref_dot(input coef_vec_t c, input sel_vec_t s, input pix_vec_t p);
        longint acc = 0;
        for (int r = 0; r < NUM_VALS; r++) begin
            longint m = longint'(c[r][KERNEL_SIZE-2:0]);
            acc += (c[r][KERNEL_SIZE-1] ? -m : m) * longint'(p[s[r]]);
        end
        return acc;
    endfunction

    function automatic longint ref_dup(input sel_vec_t s);
        int cnt [NUM_VALS];
        for (int v = 0; v < NUM_VALS; v++) cnt[v] = 0;
        for (int r = 0; r < NUM_VALS; r++) cnt[s[r]]++;
        for (int v = 0; v < NUM_VALS; v++) if (cnt[v] != 1) return 1;
        return 0;
    endfunction

    task automatic do_window(input string tag, input coef_vec_t c, input sel_vec_t s,
                             input pix_vec_t p, input int hold, output longint got);
        int lat;
        acc_t held;
        @(negedge clk);
        check({tag, "_in_ready_idle"}, bus.in_ready, 1);
        bus.sort_coef = c;
        bus.sel       = s;
        bus.pix       = p;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check({tag, "_in_ready_busy"}, bus.in_ready, 0);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, 4);
        got  = bus.result;
        held = bus.result;
        check({tag, "_result"}, bus.result, ref_dot(c, s, p));
        check({tag, "_sel_err"}, bus.sel_err, ref_dup(s));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_result"}, bus.result, held);
            check({tag, "_hold_in_ready"}, bus.in_ready, 0);
            check({tag, "_hold_out_valid"}, bus.out_valid, 1);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_post_out_valid"}, bus.out_valid, 0);
        check({tag, "_post_in_ready"}, bus.in_ready, 1);
    endtask

    coef_vec_t w1_c, ext_c;
    sel_vec_t  w1_s, bad_s, id_s;
    pix_vec_t  w1_p, ext_p;

    initial begin
        longint got;
        bit seen;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.sort_coef = '0;
        bus.sel       = '0;
        bus.pix       = '0;

        w1_c[0] = 11'b00000000000; w1_c[1] = 11'b10000000111;
        w1_c[2] = 11'b00011101000; w1_c[3] = 11'b10011111110;
        w1_s[0] = 2'd3; w1_s[1] = 2'd1; w1_s[2] = 2'd0; w1_s[3] = 2'd2;
        w1_p[0] = 9'd10; w1_p[1] = 9'd20; w1_p[2] = 9'd30; w1_p[3] = 9'd40;
        bad_s[0] = 2'd1; bad_s[1] = 2'd1; bad_s[2] = 2'd0; bad_s[3] = 2'd2;
        for (int r = 0; r < NUM_VALS; r++) begin
            id_s[r]  = sel_t'(r);
            ext_p[r] = 9'd511;
        end

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", bus.in_ready, 1);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_result", bus.result, 0);
        check("reset_sel_err", bus.sel_err, 0);

        do_window("w1", w1_c, w1_s, w1_p, 0, got);
        check("w1_literal", got, -5440);

        for (int r = 0; r < NUM_VALS; r++) ext_c[r] = 11'h3FF;
        do_window("ext_pos", ext_c, id_s, ext_p, 0, got);
        check("ext_pos_literal", got, 2091012);
        for (int r = 0; r < NUM_VALS; r++) ext_c[r] = 11'h7FF;
        do_window("ext_neg", ext_c, id_s, ext_p, 0, got);
        check("ext_neg_literal", got, -2091012);

        do_window("backpressure", w1_c, w1_s, w1_p, 10, got);

        do_window("bad_sel", w1_c, bad_s, w1_p, 0, got);

        // Abort a window two edges after it was accepted
        @(negedge clk);
        bus.sort_coef = w1_c; bus.sel = w1_s; bus.pix = w1_p;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", bus.out_valid, 0);
        check("rst_mid_in_ready", bus.in_ready, 1);
        check("rst_mid_result", bus.result, 0);
        check("rst_mid_sel_err", bus.sel_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("rst_no_stale_result", seen, 0);
        do_window("after_rst", w1_c, w1_s, w1_p, 0, got);

        // Back-to-back windows with in_valid held and out_ready high
        begin
            coef_vec_t bc [3];
            sel_vec_t  bs [3];
            pix_vec_t  bp [3];
            longint exp_q [$];
            int acc_cyc [$];
            int k = 0;
            int got_n = 0;
            bit pending = 1'b0;
            for (int w = 0; w < 3; w++)
                for (int r = 0; r < NUM_VALS; r++) begin
                    bc[w][r] = coef_t'($urandom);
                    bs[w][r] = sel_t'(r);
                    bp[w][r] = pix_t'($urandom);
                end
            @(negedge clk);
            bus.sort_coef = bc[0]; bus.sel = bs[0]; bus.pix = bp[0];
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b1;
            for (int cyc = 0; cyc < 60 && got_n < 3; cyc++) begin
                if (cyc > 0) @(negedge clk);
                if (pending) begin
                    pending = 1'b0;
                    k++;
                    if (k < 3) begin
                        bus.sort_coef = bc[k]; bus.sel = bs[k]; bus.pix = bp[k];
                    end else bus.in_valid = 1'b0;
                end
                if (bus.out_valid) begin
                    got_n++;
                    check("b2b_result", bus.result, exp_q.size() > 0 ? exp_q.pop_front() : 64'sd999999999);
                end
                if (bus.in_valid && bus.in_ready) begin
                    exp_q.push_back(ref_dot(bc[k], bs[k], bp[k]));
                    acc_cyc.push_back(cyc);
                    pending = 1'b1;
                end
            end
            check("b2b_results_seen", got_n, 3);
            check("b2b_accepts", acc_cyc.size(), 3);
            if (acc_cyc.size() == 3) begin
                check("b2b_gap1", acc_cyc[1] - acc_cyc[0], 6);
                check("b2b_gap2", acc_cyc[2] - acc_cyc[1], 6);
            end
            @(negedge clk);
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b0;
        end

        // Random windows: mostly sorted, some unsorted, some -0, some bad sel
        for (int w = 0; w < 20; w++) begin
            int m [NUM_VALS];
            coef_vec_t c;
            sel_vec_t s;
            pix_vec_t p;
            for (int r = 0; r < NUM_VALS; r++) m[r] = int'($urandom_range(0, 1023));
            if (w % 3 == 0) m[0] = 0;
            if (w % 4 != 3)
                for (int i = 0; i < NUM_VALS; i++)
                    for (int j = 0; j < NUM_VALS - 1 - i; j++)
                        if (m[j] > m[j+1]) begin
                            int t = m[j];
                            m[j] = m[j+1];
                            m[j+1] = t;
                        end
            for (int r = 0; r < NUM_VALS; r++) begin
                c[r][KERNEL_SIZE-1]   = 1'($urandom);
                c[r][KERNEL_SIZE-2:0] = (KERNEL_SIZE-1)'(m[r]);
                s[r] = sel_t'(r);
                p[r] = pix_t'($urandom);
            end
            for (int i = NUM_VALS - 1; i > 0; i--) begin
                int j = int'($urandom_range(0, i));
                sel_t t = s[i];
                s[i] = s[j];
                s[j] = t;
            end
            if (w % 5 == 4)
                for (int r = 0; r < NUM_VALS; r++) s[r] = sel_t'($urandom);
            do_window("rnd", c, s, p, w % 3, got);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
